// File: rtl/uart_pkg.sv
// Shared UART definitions, also used by the transmitter.
//   rx_state_e  receiver FSM states
//   OVERSAMPLE  oversampling ticks per bit
//   MID_TICK    tick index at the middle of the start bit
//   max_int     constant helper for counter sizing
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk    system clock
//   rst_n  synchronous active-low reset; both flops load RST_VAL
//   d      asynchronous input
//   q      synchronised output, two clocks behind d
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver driven by a 16x oversampling tick.
//   clk_i        system clock
//   rst_ni       synchronous active-low reset
//   tick_i       one-cycle pulse at 16x the baud rate
//   rx_i         asynchronous serial line, idle high
//   data_o       received word, held while valid_o is high
//   valid_o      data_o holds an unconsumed word
//   ready_i      consumer takes data_o when valid_o & ready_i
//   frame_err_o  one-cycle pulse: stop bit sampled low
//   overrun_o    one-cycle pulse: good frame dropped because output is full
//   busy_o       receiver is inside a frame
//
// state | meaning
// IDLE  | waiting for the line to go low
// START | counting to the middle of the start bit, rejects glitches
// DATA  | sampling DBIT data bits at bit centres, LSB first
// STOP  | waiting out the stop period, then checking the stop level
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            tick_i,
    input  logic            rx_i,
    output logic [DBIT-1:0] data_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            frame_err_o,
    output logic            overrun_o,
    output logic            busy_o
);

    localparam int SW = $clog2(max_int(SB_TICK, OVERSAMPLE));
    localparam int NW = $clog2(DBIT);

    localparam logic [SW-1:0] S_MID      = SW'(MID_TICK);
    localparam logic [SW-1:0] S_BIT_END  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

    logic rx_s;

    rx_state_e       state_q, state_d;
    logic [SW-1:0]   s_cnt_q, s_cnt_d;
    logic [NW-1:0]   n_cnt_q, n_cnt_d;
    logic [DBIT-1:0] shreg_q, shreg_d;
    logic [DBIT-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic            frame_good;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .d     (rx_i),
        .q     (rx_s)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        s_cnt_d    = s_cnt_q;
        n_cnt_d    = n_cnt_q;
        shreg_d    = shreg_q;
        frame_good = 1'b0;
        ferr_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Leave on the first low sample, no tick needed, so
                // back-to-back frames need no idle bits.
                if (!rx_s) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end
            START: begin
                if (tick_i) begin
                    if (s_cnt_q == S_MID) begin
                        s_cnt_d = '0;
                        if (!rx_s) begin
                            state_d = DATA;
                            n_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick_i) begin
                    if (s_cnt_q == S_BIT_END) begin
                        s_cnt_d = '0;
                        shreg_d = {rx_s, shreg_q[DBIT-1:1]};
                        if (n_cnt_q == N_LAST) begin
                            state_d = STOP;
                            n_cnt_d = '0;
                        end else begin
                            n_cnt_d = n_cnt_q + NW'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (tick_i) begin
                    if (s_cnt_q == S_STOP_END) begin
                        state_d    = IDLE;
                        s_cnt_d    = '0;
                        frame_good = rx_s;
                        ferr_d     = ~rx_s;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register: a new word may replace one being consumed in the
    // same cycle; otherwise a full register drops the new word.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (frame_good && !(valid_q && !ready_i)) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
        end else begin
            if (frame_good) begin
                ovr_d = 1'b1;
            end
            if (valid_q && ready_i) begin
                valid_d = 1'b0;
            end
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, overrun, busy;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .tick_i      (tick),
        .rx_i        (rx),
        .data_o      (data),
        .valid_o     (valid),
        .ready_i     (ready),
        .frame_err_o (frame_err),
        .overrun_o   (overrun),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Baud generator, divisor 4: one tick every 4 clocks, 64 clocks per bit.
    int tcnt = 0;
    always @(negedge clk) begin
        tcnt = (tcnt == 3) ? 0 : tcnt + 1;
        tick = (tcnt == 3);
    end

    bit rnd_rdy = 1'b0;
    always @(negedge clk) begin
        if (rnd_rdy) ready = 1'($urandom_range(0, 1));
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    // A frame is: line seen low while idle, 8 ticks later the start level is
    // checked, then each data bit is taken 16 ticks after the previous
    // sample, then the stop level 16 ticks later.  The line is seen through
    // a two-clock synchroniser delay.
    typedef enum {EV_NONE, EV_GOOD, EV_ERR} ev_e;

    bit         m_ff1 = 1'b1, m_ff2 = 1'b1;
    bit         s_tk, s_rxs, s_rdy;
    logic [7:0] e_data = '0;
    bit         e_valid = 0, e_ferr = 0, e_ovr = 0, e_busy = 0;

    task automatic step(output bit ok);
        @(posedge clk);
        s_tk  = tick;
        s_rdy = ready;
        s_rxs = m_ff2;
        if (!rst_n) begin
            m_ff1 = 1; m_ff2 = 1;
            e_data = '0; e_valid = 0; e_ferr = 0; e_ovr = 0; e_busy = 0;
            ok = 0;
        end else begin
            m_ff2 = m_ff1;
            m_ff1 = rx;
            ok = 1;
        end
    endtask

    task automatic finish(input ev_e ev, input logic [7:0] b, input bit busy_after);
        e_ferr = 0;
        e_ovr  = 0;
        e_busy = busy_after;
        if (ev == EV_GOOD && !(e_valid && !s_rdy)) begin
            e_data  = b;
            e_valid = 1;
        end else begin
            if (ev == EV_GOOD) e_ovr = 1;
            if (e_valid && s_rdy) e_valid = 0;
        end
        if (ev == EV_ERR) e_ferr = 1;
    endtask

    // Returns on the edge carrying the n-th tick, leaving that edge unfinished.
    task automatic wait_ticks(input int n, output bit ok);
        int t = 0;
        while (1) begin
            step(ok);
            if (!ok) return;
            if (s_tk) begin
                t++;
                if (t == n) return;
            end
            finish(EV_NONE, '0, 1);
        end
    endtask

    initial begin : model
        bit ok;
        logic [7:0] b;
        forever begin
            step(ok);
            if (!ok) continue;
            if (s_rxs) begin finish(EV_NONE, '0, 0); continue; end
            finish(EV_NONE, '0, 1);
            wait_ticks(8, ok);
            if (!ok) continue;
            if (s_rxs) begin finish(EV_NONE, '0, 0); continue; end
            finish(EV_NONE, '0, 1);
            b = '0;
            for (int i = 0; i < 8 && ok; i++) begin
                wait_ticks(16, ok);
                if (ok) begin
                    b[i] = s_rxs;
                    finish(EV_NONE, '0, 1);
                end
            end
            if (!ok) continue;
            wait_ticks(16, ok);
            if (!ok) continue;
            finish(s_rxs ? EV_GOOD : EV_ERR, b, 0);
        end
    end

    // ---------------- per-cycle compare and event logs ----------------
    bit         chk_en = 0;
    bit         pv = 0, pr = 0;
    logic [7:0] got_q[$];
    int         ferr_cnt = 0, ovr_cnt = 0, vcyc = 0;

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("data_o",      32'(data),      32'(e_data));
            check("valid_o",     32'(valid),     32'(e_valid));
            check("frame_err_o", 32'(frame_err), 32'(e_ferr));
            check("overrun_o",   32'(overrun),   32'(e_ovr));
            check("busy_o",      32'(busy),      32'(e_busy));
        end
        if (valid === 1'b1 && (!pv || pr)) got_q.push_back(data);
        if (frame_err === 1'b1) ferr_cnt++;
        if (overrun === 1'b1) ovr_cnt++;
        if (valid === 1'b1) vcyc++;
        pv = (valid === 1'b1);
        pr = ready;
    end

    task automatic clear_logs();
        got_q.delete();
        ferr_cnt = 0; ovr_cnt = 0; vcyc = 0;
    endtask

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        drive(0, 64);
        for (int i = 0; i < 8; i++) drive(b[i], 64);
        if (stop_ok) drive(1, 64);
        else begin
            // Low for three quarters of the bit so the line is high again
            // before the mid-start check that follows the bad stop.
            drive(0, 48);
            drive(1, 16);
        end
    endtask

    initial begin
        logic [7:0] frame_5a;
        @(negedge clk);
        rst_n = 0; rx = 1; ready = 1;
        repeat (3) @(negedge clk);
        rst_n = 1;
        chk_en = 1;
        @(negedge clk);
        check("reset valid_o", 32'(valid), 32'd0);
        check("reset data_o",  32'(data),  32'd0);
        check("reset busy_o",  32'(busy),  32'd0);
        drive(1, 37);

        // 1: single good frame
        clear_logs();
        send_frame(8'h55, 1);
        drive(1, 8);
        check("t1 byte count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check("t1 data", 32'(got_q[0]), 32'h55);
        check("t1 valid cycles", 32'(vcyc), 32'd1);
        check("t1 frame_err", 32'(ferr_cnt), 32'd0);
        check("t1 overrun", 32'(ovr_cnt), 32'd0);

        // 2: short low glitch on the idle line
        clear_logs();
        drive(0, 20);
        drive(1, 100);
        check("t2 byte count", 32'(got_q.size()), 32'd0);
        check("t2 frame_err", 32'(ferr_cnt), 32'd0);
        check("t2 busy_o", 32'(busy), 32'd0);

        // 3: bad stop bit
        clear_logs();
        send_frame(8'hA3, 0);
        drive(1, 100);
        check("t3 frame_err pulses", 32'(ferr_cnt), 32'd1);
        check("t3 byte count", 32'(got_q.size()), 32'd0);

        // 4: consumer stalled, second frame overruns
        clear_logs();
        ready = 0;
        send_frame(8'h11, 1);
        send_frame(8'h22, 1);
        drive(1, 8);
        check("t4 valid_o", 32'(valid), 32'd1);
        check("t4 data_o", 32'(data), 32'h11);
        check("t4 overrun pulses", 32'(ovr_cnt), 32'd1);
        ready = 1;
        @(posedge clk);
        #2;
        check("t4 valid after ready", 32'(valid), 32'd0);
        @(negedge clk);

        // 5: back-to-back frames, no idle gap
        clear_logs();
        send_frame(8'h00, 1);
        send_frame(8'hFF, 1);
        send_frame(8'h81, 1);
        drive(1, 20);
        check("t5 byte count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            check("t5 byte0", 32'(got_q[0]), 32'h00);
            check("t5 byte1", 32'(got_q[1]), 32'hFF);
            check("t5 byte2", 32'(got_q[2]), 32'h81);
        end
        check("t5 errors", 32'(ferr_cnt + ovr_cnt), 32'd0);

        // 6: reset in the middle of data bit 3
        clear_logs();
        frame_5a = 8'h5A;
        drive(0, 64);
        for (int i = 0; i < 3; i++) drive(frame_5a[i], 64);
        drive(frame_5a[3], 32);
        check("t6 busy mid-frame", 32'(busy), 32'd1);
        rst_n = 0; rx = 1;
        repeat (3) @(negedge clk);
        rst_n = 1;
        drive(1, 200);
        check("t6 valid_o", 32'(valid), 32'd0);
        check("t6 busy_o", 32'(busy), 32'd0);
        check("t6 outputs", 32'({data, frame_err, overrun}), 32'd0);
        check("t6 byte count", 32'(got_q.size()), 32'd0);
        send_frame(8'h3C, 1);
        drive(1, 8);
        check("t6 byte count after", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check("t6 data after", 32'(got_q[0]), 32'h3C);

        // Randomised traffic: random bytes, gaps, bad stops, glitches and
        // consumer stalls, checked cycle by cycle against the model.
        rnd_rdy = 1;
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                drive(0, $urandom_range(1, 24));
                drive(1, 40);
            end
            send_frame(8'($urandom), $urandom_range(0, 7) != 0);
            drive(1, $urandom_range(0, 90));
        end
        rnd_rdy = 0;
        ready = 1;
        drive(1, 100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
